fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
// - Shares one synchronous_fifo write port between N producers.
// - Arbitration is round-robin. A winner may keep the port for a burst of up to MAX_BURST beats.
// - Drives the FIFO's w_en/data_in and honours its full flag. Sits directly in front of the FIFO.
// PARAMETERS
// - N_REQ      4  number of requesters (>=2)
// - DATA_WIDTH 8  FIFO data width
// - MAX_BURST  4  max consecutive beats per grant (>=1; 1 = pure per-beat round-robin)
// PORTS
// - clk           in   1             clock, rising edge
// - rst_n         in   1             async reset, active-low
// - req_valid     in   N_REQ         requester i has a beat pending
// - req_data      in   N_REQ*DW      beat of requester i at [i*DW +: DW]
// - req_ready     out  N_REQ         beat of requester i accepted this cycle
// - fifo_w_en     out  1             to FIFO w_en
// - fifo_data_in  out  DW            to FIFO data_in
// - fifo_full     in   1             from FIFO full
// BEHAVIOUR
// - Decided: one clock (clk); reset is asynchronous and active-low (rst_n).
// - Reset values: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, all stats counters=0.
// - Outputs are combinational from state and inputs: req_ready, fifo_w_en=|req_ready, fifo_data_in.
// - Zero latency: the beat is written on the same edge as its req_ready.
// - Handshake: a beat transfers when req_valid[i] & req_ready[i].
//   - Requester holds data stable while valid and not ready.
//   - req_ready is never high while fifo_full=1.
//   - req_ready is at most one-hot.
// - fifo_data_in is req_data of the granted index; it is 0 when nothing is granted.
// - FSM IDLE:
//   - Winner = first set req_valid scanning rr_ptr, rr_ptr+1, ... with wrap mod N_REQ.
//   - If a winner exists and !fifo_full: accept its beat. The winner is granted the same cycle.
//   - On accept with MAX_BURST>1: owner<=winner, burst_cnt<=1, go BURST.
//   - On accept with MAX_BURST==1: rr_ptr<=winner+1 (wrap), stay IDLE.
//   - fifo_full or no valid: no accept, no state change.
// - FSM BURST:
//   - Only owner is eligible; other requesters see req_ready=0.
//   - Accept when req_valid[owner] & !fifo_full; then burst_cnt++.
//   - When the accepted beat makes burst_cnt==MAX_BURST: go IDLE, rr_ptr<=owner+1.
//   - req_valid[owner]==0: go IDLE, rr_ptr<=owner+1. No transfer this cycle.
//   - fifo_full with owner valid: stall, hold state. Stall cycles do not count toward the burst.
// - burst_cnt width is $clog2(MAX_BURST+1). rr_ptr/owner width is $clog2(N_REQ). Pointer wrap uses explicit modulo.
// - Fairness: every continuously-valid requester gets a grant within (N_REQ-1)*MAX_BURST accepted beats.
// - Async reset mid-burst: immediately IDLE; the in-progress burst is abandoned, with no partial write.
// CONFIGURATION
// - Macro FIFO_ARB_STATS_EN.
// - Defined: adds output beat_cnt [N_REQ*16].
//   - One 16-bit saturating counter of accepted beats per requester; counter i at [i*16 +: 16].
//   - Saturates at 16'hFFFF; cleared only by rst_n.
// - Undefined: port and counters absent. Arbitration behaviour is identical.
// STRUCTURE
// - Package fifo_arb_pkg:
//   - arb_state_e enum {IDLE, BURST}
//   - localparam function clog2_min1 (min 1 bit)
// - Sub-module rr_picker: combinational.
//   - Inputs valid[N_REQ] and ptr; outputs one-hot grant plus index and any_valid.
//   - Used in the IDLE state only.
// - Top level holds the FSM, burst counter, rr_ptr, output mux and optional stats.
// TESTING
// - Bench pairs the arbiter with synchronous_fifo and checks data against a scoreboard queue per requester.
// - T1 Reset: hold rst_n=0 for 10 clk.
//   -> req_ready=0, fifo_w_en=0, fifo_data_in=0; after release, first winner scan starts at 0.
// - T2 Single requester: req_valid=4'b0100, 6 beats 0x10..0x15, MAX_BURST=4.
//   -> bursts of 4 then 2 beats; FIFO reads back 0x10..0x15 in order.
// - T3 All four requesters valid continuously, MAX_BURST=4.
//   -> grant order 0,0,0,0,1x4,2x4,3x4,0...; never two req_ready bits high.
// - T4 Force fifo_full=1 for 5 cycles mid-burst (owner=2, burst_cnt=2).
//   -> req_ready=0 throughout; the burst resumes afterwards with 2 more beats from requester 2.
// - T5 Owner 1 drops valid after 1 beat.
//   -> next cycle IDLE with rr_ptr=2; requester 2 wins over 0 when both are valid.
// - T6 Assert rst_n=0 during a burst; with FIFO_ARB_STATS_EN, drive 65540 beats from requester 3.
//   -> reset yields IDLE and no write; beat_cnt[3] saturates at 0xFFFF.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional statistics are enabled by defining FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // $clog2 that never returns zero, so a 1-entry range still gets a 1-bit field.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin scan: first valid requester starting at ptr_i, wrapping modulo N_REQ.
// Purely combinational; the arbiter consults it only while idle.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_valid_o
);

  logic [PTR_W-1:0] cand_s;

  // Scan candidates in priority order and latch the first hit.
  always_comb begin
    grant_o     = '0;
    idx_o       = '0;
    any_valid_o = 1'b0;
    cand_s      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = PTR_W'((int'(ptr_i) + k) % N_REQ);
      if (!any_valid_o && valid_i[cand_s]) begin
        any_valid_o = 1'b1;
        idx_o       = cand_s;
      end else begin
        any_valid_o = any_valid_o;
      end
    end
    grant_o = any_valid_o ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-requester saturating beat counters (beat_cnt).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        fifo_w_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]         beat_cnt
`endif
);

  localparam int PTR_W = clog2_min1(N_REQ);
  localparam int CNT_W = clog2_min1(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] burst_inc_s;

  logic [N_REQ-1:0] pick_grant_s;
  logic [PTR_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic             grant_any_s;
  logic             can_write_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return PTR_W'((int'(p) + 1) % N_REQ);
  endfunction

  rr_picker #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_picker (
    .valid_i    (req_valid),
    .ptr_i      (rr_ptr_q),
    .grant_o    (pick_grant_s),
    .idx_o      (pick_idx_s),
    .any_valid_o(pick_any_s)
  );

  // No write may happen while reset is asserted, so rst_n also gates acceptance.
  assign can_write_s = rst_n & ~fifo_full;
  assign burst_inc_s = burst_cnt_q + CNT_W'(1);

  // Next-state, grant and pointer update logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    req_ready   = '0;
    grant_idx_s = owner_q;
    grant_any_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any_s && can_write_s) begin
          req_ready   = pick_grant_s;
          grant_idx_s = pick_idx_s;
          grant_any_s = 1'b1;
          if (MAX_BURST > 1) begin
            owner_d     = pick_idx_s;
            burst_cnt_d = CNT_W'(1);
            state_d     = BURST;
          end else begin
            rr_ptr_d = ptr_next(pick_idx_s);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (!req_valid[owner_q]) begin
          state_d     = IDLE;
          rr_ptr_d    = ptr_next(owner_q);
          burst_cnt_d = '0;
        end else if (can_write_s) begin
          req_ready[owner_q] = 1'b1;
          grant_any_s        = 1'b1;
          if (burst_inc_s == CNT_W'(MAX_BURST)) begin
            state_d     = IDLE;
            rr_ptr_d    = ptr_next(owner_q);
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_inc_s;
          end
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // FSM, pointer, owner and burst-length registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign fifo_w_en    = |req_ready;
  assign fifo_data_in = grant_any_s ? req_data[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH]
                                    : {DATA_WIDTH{1'b0}};

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_stats
    logic [15:0] cnt_q;

    // Saturating count of accepted beats for requester g.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= 16'h0000;
      end else if (req_ready[g] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'h0001;
      end
    end

    assign beat_cnt[g*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with a queue standing in for the FIFO.
// Statistics checks run only when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_data_in;
  logic            fifo_full;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] beat_cnt;
`endif

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_w_en   (fifo_w_en),
    .fifo_data_in(fifo_data_in),
    .fifo_full   (fifo_full)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_cnt    (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rem [N];
  logic [7:0]  dat [N];
  logic [7:0]  fifo_q [$];
  int          gseq [$];
  logic [N-1:0] obs_ready;
  logic         obs_wen;
  logic [DW-1:0] obs_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = (rem[i] > 0);
      req_data[i*DW +: DW] = dat[i];
    end
  endtask

  // Observe one cycle just after the falling edge, then advance to the next falling edge.
  task automatic tick();
    int gi;
    #1;
    obs_ready = req_ready;
    obs_wen   = fifo_w_en;
    obs_data  = fifo_data_in;
    chk("onehot", 32'($countones(obs_ready) <= 1), 32'd1);
    chk("wen_vs_ready", 32'(obs_wen), 32'(|obs_ready));
    if (fifo_full) chk("ready_while_full", 32'(obs_ready), 32'd0);
    if (obs_wen) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (obs_ready[i]) gi = i;
      fifo_q.push_back(obs_data);
      gseq.push_back(gi);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (obs_ready[i] && req_valid[i]) begin
        rem[i]--;
        dat[i] = dat[i] + 8'd1;
      end
    end
    drive();
  endtask

  task automatic chk_beats(input string tag, input int idx, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      if (gseq.size() == 0) begin
        chk({tag, "_missing"}, 32'd0, 32'd1);
        return;
      end
      chk({tag, "_idx"}, 32'(gseq.pop_front()), 32'(idx));
      chk({tag, "_data"}, 32'(fifo_q.pop_front()), 32'(first + 8'(k)));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 1000;
      dat[i] = 8'(i * 64);
    end
    drive();

    // T1: reset holds everything quiet even with all requesters valid
    repeat (10) @(negedge clk);
    #1;
    chk("t1_ready", 32'(req_ready), 32'd0);
    chk("t1_wen", 32'(fifo_w_en), 32'd0);
    chk("t1_data", 32'(fifo_data_in), 32'd0);
    rst_n = 1'b1;

    // T3: all valid -> 0x4, 1x4, 2x4, 3x4, 0x4
    repeat (20) tick();
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive();
    chk_beats("t3_r0a", 0, 8'h00, 4);
    chk_beats("t3_r1", 1, 8'h40, 4);
    chk_beats("t3_r2", 2, 8'h80, 4);
    chk_beats("t3_r3", 3, 8'hC0, 4);
    chk_beats("t3_r0b", 0, 8'h04, 4);
    chk("t3_extra", 32'(gseq.size()), 32'd0);

    // T2: single requester, bursts of 4 then 2, then owner-drop exit
    rem[2] = 6;
    dat[2] = 8'h10;
    drive();
    repeat (6) tick();
    tick();
    chk("t2_exit_wen", 32'(obs_wen), 32'd0);
    chk_beats("t2", 2, 8'h10, 6);
    chk("t2_extra", 32'(gseq.size()), 32'd0);

    // T4: stall mid-burst (owner 2, two beats done), requester 0 waits
    rem[2] = 4;
    dat[2] = 8'h20;
    drive();
    repeat (2) tick();
    fifo_full = 1'b1;
    rem[0] = 1;
    dat[0] = 8'h55;
    drive();
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t4_stall_ready", 32'(obs_ready), 32'd0);
      chk("t4_stall_wen", 32'(obs_wen), 32'd0);
    end
    fifo_full = 1'b0;
    repeat (2) tick();
    tick();
    chk("t4_next_grant", 32'(obs_ready), 32'h1);
    tick();
    chk_beats("t4_r2", 2, 8'h20, 4);
    chk_beats("t4_r0", 0, 8'h55, 1);
    chk("t4_extra", 32'(gseq.size()), 32'd0);

    // T5: owner 1 drops after one beat; pointer moves to 2
    rem[1] = 1;
    dat[1] = 8'h31;
    drive();
    tick();
    chk("t5_first", 32'(obs_ready), 32'h2);
    tick();
    chk("t5_drop_wen", 32'(obs_wen), 32'd0);
    rem[0] = 1;
    dat[0] = 8'h60;
    rem[2] = 1;
    dat[2] = 8'h62;
    drive();
    tick();
    chk("t5_r2_wins", 32'(obs_ready), 32'h4);
    tick();
    tick();
    chk("t5_r0_next", 32'(obs_ready), 32'h1);
    tick();
    chk_beats("t5_r1", 1, 8'h31, 1);
    chk_beats("t5_r2", 2, 8'h62, 1);
    chk_beats("t5_r0", 0, 8'h60, 1);

    // T6: reset during a burst from requester 3
    rem[3] = 10;
    dat[3] = 8'h70;
    drive();
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_wen", 32'(fifo_w_en), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("t6_rst_hold_wen", 32'(fifo_w_en), 32'd0);
    @(negedge clk);
    rem[3] = 0;
    rem[0] = 1;
    dat[0] = 8'h80;
    drive();
    rst_n = 1'b1;
    tick();
    chk("t6_after_rst", 32'(obs_ready), 32'h1);
    tick();
    chk_beats("t6_r3", 3, 8'h70, 2);
    chk_beats("t6_r0", 0, 8'h80, 1);
    chk("t6_extra", 32'(gseq.size()), 32'd0);

`ifdef FIFO_ARB_STATS_EN
    chk("stats_r0", 32'(beat_cnt[0 +: 16]), 32'h1);
    chk("stats_r3_clr", 32'(beat_cnt[48 +: 16]), 32'h0);
    rem[3] = 65540;
    dat[3] = 8'h00;
    drive();
    for (int b = 0; b < 70000 && rem[3] > 0; b++) begin
      tick();
      if (gseq.size() > 64) begin
        fifo_q.delete();
        gseq.delete();
      end
    end
    chk("stats_done", 32'(rem[3]), 32'd0);
    chk("stats_r3_sat", 32'(beat_cnt[48 +: 16]), 32'hFFFF);
    chk("stats_r0_keep", 32'(beat_cnt[0 +: 16]), 32'h1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
